// File: rtl/riscv_imm_sel_ctrl.sv
// riscv_imm_sel_ctrl: feeds one instruction at a time to a registered immediate generator and returns the selected immediate over valid/ready.
// Optional statistics counters are enabled by defining RISCV_IMM_SEL_CTRL_STATS_EN.
module riscv_imm_sel_ctrl #(
    parameter int GEN_LATENCY = 1
`ifdef RISCV_IMM_SEL_CTRL_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_instr,
    output logic [31:0] gen_instr,
    input  logic [31:0] gen_i_imm,
    input  logic [31:0] gen_s_imm,
    input  logic [31:0] gen_b_imm,
    input  logic [31:0] gen_u_imm,
    input  logic [31:0] gen_j_imm,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_imm,
    output logic [2:0]  m_fmt,
    output logic        m_illegal,
    output logic        busy
`ifdef RISCV_IMM_SEL_CTRL_STATS_EN
    , output logic [CNT_W-1:0] stat_instr_cnt,
    output logic [CNT_W-1:0] stat_illegal_cnt
`endif
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2;
    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  fmt_q;
    logic [2:0]  dec_fmt;
    logic [31:0] sel_imm;
    logic        accept;
    logic        hs;
    assign s_ready = (state == IDLE) || (state == HOLD && m_ready);
    assign accept  = s_valid && s_ready;
    assign hs      = m_valid && m_ready;
    assign busy    = state != IDLE;
    always_comb begin
        case (s_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = 3'd1;
            7'b0100011:                                     dec_fmt = 3'd2;
            7'b1100011:                                     dec_fmt = 3'd3;
            7'b0110111, 7'b0010111:                         dec_fmt = 3'd4;
            7'b1101111:                                     dec_fmt = 3'd5;
            7'b0110011:                                     dec_fmt = 3'd0;
            default:                                        dec_fmt = 3'd7;
        endcase
    end
    // R-type and illegal instructions fall through to a zero immediate
    always_comb
        sel_imm = fmt_q == 3'd1 ? gen_i_imm :
                  fmt_q == 3'd2 ? gen_s_imm :
                  fmt_q == 3'd3 ? gen_b_imm :
                  fmt_q == 3'd4 ? gen_u_imm :
                  fmt_q == 3'd5 ? gen_j_imm : 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gen_instr <= 32'h0000_0013;
            fmt_q     <= 3'd0;
            cnt       <= 3'd0;
            m_valid   <= 1'b0;
            m_imm     <= 32'd0;
            m_fmt     <= 3'd0;
            m_illegal <= 1'b0;
        end else if (accept) begin
            gen_instr <= s_instr;
            fmt_q     <= dec_fmt;
            cnt       <= 3'(GEN_LATENCY);
            m_valid   <= 1'b0;
            state     <= ISSUE;
        end else if (hs) begin
            m_valid <= 1'b0;
            state   <= IDLE;
        end else if (state == ISSUE) begin
            if (cnt == 3'd0) begin
                m_imm     <= sel_imm;
                m_fmt     <= fmt_q;
                m_illegal <= fmt_q == 3'd7;
                m_valid   <= 1'b1;
                state     <= HOLD;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end
`ifdef RISCV_IMM_SEL_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_instr_cnt   <= '0;
            stat_illegal_cnt <= '0;
        end else if (hs) begin
            if (!(&stat_instr_cnt)) stat_instr_cnt <= stat_instr_cnt + CNT_W'(1);
            if (m_illegal && !(&stat_illegal_cnt)) stat_illegal_cnt <= stat_illegal_cnt + CNT_W'(1);
        end
    end
`endif
endmodule
